ngp_commit: RTL and testbench



---
 rtl/ngp_commit.sv | 84 ++++++++
 tb/tb_ngp_commit.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/ngp_commit.sv
// ngp_commit: commit/writeback stage of the nandgameplus core.
//   Retires execute-stage results into X/Y, advances or redirects the PC, and
//   performs *X memory writes through a registered request/grant handshake.
//   Ports:
//     clk, rst_n              clock, asynchronous active-low reset
//     ex_valid/ex_ready       result handshake from execute (ready from state only)
//     ex_out, ex_jmp, ex_dst  result value, branch taken, dest mask {X,Y,*X}
//     rx_reg, ry_reg          architectural X/Y fed back to execute
//     pc, redirect            fetch PC and one-cycle taken-jump pulse
//     mem_req/mem_gnt         write request/grant
//     mem_addr, mem_wdata     write address/data, stable while mem_req is high
module ngp_commit #(
  parameter int WIDTH = 16,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  output logic             ex_ready,
  input  logic [WIDTH-1:0] ex_out,
  input  logic             ex_jmp,
  input  logic [2:0]       ex_dst,
  output logic [WIDTH-1:0] rx_reg,
  output logic [WIDTH-1:0] ry_reg,
  output logic [WIDTH-1:0] pc,
  output logic             redirect,
  output logic             mem_req,
  input  logic             mem_gnt,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata
);
  localparam logic S_RUN  = 1'b0;
  localparam logic S_MEMW = 1'b1;
  logic             r_state;
  logic [WIDTH-1:0] r_rx;
  logic [WIDTH-1:0] r_ry;
  logic [WIDTH-1:0] r_pc;
  logic             r_redirect;
  logic             r_mem_req;
  logic [WIDTH-1:0] r_mem_addr;
  logic [WIDTH-1:0] r_mem_wdata;
  logic             w_accept;
  logic             w_done;
  assign ex_ready  = (r_state == S_RUN);
  assign w_accept  = ex_valid && ex_ready;
  // A grant only counts against a request that is already registered high.
  assign w_done    = (r_state == S_MEMW) && r_mem_req && mem_gnt;
  assign rx_reg    = r_rx;
  assign ry_reg    = r_ry;
  assign pc        = r_pc;
  assign redirect  = r_redirect;
  assign mem_req   = r_mem_req;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  // Jump target and write address both use X as it was before this commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_RUN;
      r_rx        <= '0;
      r_ry        <= '0;
      r_pc        <= RESET_PC;
      r_redirect  <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_redirect <= w_accept && ex_jmp;
      if (w_accept) begin
        if (ex_dst[2]) r_rx <= ex_out;
        if (ex_dst[1]) r_ry <= ex_out;
        if (ex_dst[0]) begin
          r_mem_addr  <= r_rx;
          r_mem_wdata <= ex_out;
          r_mem_req   <= 1'b1;
          r_state     <= S_MEMW;
        end
        r_pc <= ex_jmp ? r_rx : r_pc + 1'b1;
      end else if (w_done) begin
        r_mem_req <= 1'b0;
        r_state   <= S_RUN;
      end
    end
  end
endmodule

// File: tb/tb_ngp_commit.sv
// tb_ngp_commit: directed self-checking bench for ngp_commit.
module tb_ngp_commit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic        ex_ready;
  logic [15:0] ex_out;
  logic        ex_jmp;
  logic [2:0]  ex_dst;
  logic [15:0] rx_reg;
  logic [15:0] ry_reg;
  logic [15:0] pc;
  logic        redirect;
  logic        mem_req;
  logic        mem_gnt;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  int n_chk = 0;
  int n_fail = 0;
  ngp_commit #(.WIDTH(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_out(ex_out), .ex_jmp(ex_jmp), .ex_dst(ex_dst), .rx_reg(rx_reg),
    .ry_reg(ry_reg), .pc(pc), .redirect(redirect), .mem_req(mem_req),
    .mem_gnt(mem_gnt), .mem_addr(mem_addr), .mem_wdata(mem_wdata)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [2:0] d, input logic [15:0] o, input logic j);
    ex_valid = v;
    ex_dst = d;
    ex_out = o;
    ex_jmp = j;
  endtask
  task automatic regs(input string tag, input logic [15:0] x, input logic [15:0] y, input logic [15:0] p);
    chk({tag, ".rx"}, rx_reg, x);
    chk({tag, ".ry"}, ry_reg, y);
    chk({tag, ".pc"}, pc, p);
  endtask
  initial begin
    rst_n = 1'b0;
    mem_gnt = 1'b0;
    drive(1'b0, 3'b000, 16'h0000, 1'b0);
    #12;
    regs("rst", 16'h0000, 16'h0000, 16'h0000);
    chk("rst.req", {15'd0, mem_req}, 16'd0);
    chk("rst.redir", {15'd0, redirect}, 16'd0);
    chk("rst.addr", mem_addr, 16'h0000);
    chk("rst.wdata", mem_wdata, 16'h0000);
    #5 rst_n = 1'b1;
    step;
    chk("rst.ready", {15'd0, ex_ready}, 16'd1);
    // write X only
    drive(1'b1, 3'b100, 16'h1234, 1'b0);
    step;
    regs("wx", 16'h1234, 16'h0000, 16'h0001);
    chk("wx.req", {15'd0, mem_req}, 16'd0);
    chk("wx.ready", {15'd0, ex_ready}, 16'd1);
    // X = 0x0040, then store *X with a 4-cycle grant delay
    drive(1'b1, 3'b100, 16'h0040, 1'b0);
    step;
    regs("x40", 16'h0040, 16'h0000, 16'h0002);
    drive(1'b1, 3'b001, 16'hBEEF, 1'b0);
    step;
    drive(1'b1, 3'b110, 16'hDEAD, 1'b0);
    for (int i = 0; i < 4; i++) begin
      mem_gnt = (i == 3);
      chk("st.req", {15'd0, mem_req}, 16'd1);
      chk("st.addr", mem_addr, 16'h0040);
      chk("st.wdata", mem_wdata, 16'hBEEF);
      chk("st.ready", {15'd0, ex_ready}, 16'd0);
      regs("st", 16'h0040, 16'h0000, 16'h0003);
      step;
    end
    drive(1'b0, 3'b000, 16'h0000, 1'b0);
    chk("st.done.req", {15'd0, mem_req}, 16'd0);
    chk("st.done.ready", {15'd0, ex_ready}, 16'd1);
    regs("st.done", 16'h0040, 16'h0000, 16'h0003);
    // stray grant with no request and no accept: nothing moves
    step;
    mem_gnt = 1'b0;
    chk("idle.req", {15'd0, mem_req}, 16'd0);
    chk("idle.redir", {15'd0, redirect}, 16'd0);
    regs("idle", 16'h0040, 16'h0000, 16'h0003);
    // jump to old X while writing X and *X
    drive(1'b1, 3'b100, 16'h0200, 1'b0);
    step;
    regs("x200", 16'h0200, 16'h0000, 16'h0004);
    drive(1'b1, 3'b101, 16'h0300, 1'b1);
    step;
    drive(1'b0, 3'b000, 16'h0000, 1'b0);
    mem_gnt = 1'b1;
    regs("jmp", 16'h0300, 16'h0000, 16'h0200);
    chk("jmp.redir", {15'd0, redirect}, 16'd1);
    chk("jmp.req", {15'd0, mem_req}, 16'd1);
    chk("jmp.addr", mem_addr, 16'h0200);
    chk("jmp.wdata", mem_wdata, 16'h0300);
    chk("jmp.ready", {15'd0, ex_ready}, 16'd0);
    step;
    mem_gnt = 1'b0;
    chk("jmp.redir1", {15'd0, redirect}, 16'd0);
    chk("jmp.done.req", {15'd0, mem_req}, 16'd0);
    chk("jmp.done.ready", {15'd0, ex_ready}, 16'd1);
    // reach pc=0xFFFF, then check wrap with dst=000
    drive(1'b1, 3'b100, 16'hFFFF, 1'b0);
    step;
    regs("xffff", 16'hFFFF, 16'h0000, 16'h0201);
    drive(1'b1, 3'b000, 16'h1111, 1'b1);
    step;
    regs("pcffff", 16'hFFFF, 16'h0000, 16'hFFFF);
    chk("pcffff.redir", {15'd0, redirect}, 16'd1);
    drive(1'b1, 3'b000, 16'h2222, 1'b0);
    step;
    regs("wrap", 16'hFFFF, 16'h0000, 16'h0000);
    chk("wrap.redir", {15'd0, redirect}, 16'd0);
    chk("wrap.req", {15'd0, mem_req}, 16'd0);
    // back-to-back Y writes
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 3'b010, 16'(i), 1'b0);
      step;
      regs("b2b", 16'hFFFF, 16'(i), 16'(i));
      chk("b2b.ready", {15'd0, ex_ready}, 16'd1);
    end
    // reset in the middle of a pending write
    drive(1'b1, 3'b001, 16'h5555, 1'b0);
    step;
    drive(1'b0, 3'b000, 16'h0000, 1'b0);
    chk("mrst.pre.req", {15'd0, mem_req}, 16'd1);
    chk("mrst.pre.addr", mem_addr, 16'hFFFF);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst.req", {15'd0, mem_req}, 16'd0);
    chk("mrst.ready", {15'd0, ex_ready}, 16'd1);
    #4 rst_n = 1'b1;
    step;
    regs("mrst.post", 16'h0000, 16'h0000, 16'h0000);
    chk("mrst.post.ready", {15'd0, ex_ready}, 16'd1);
    chk("mrst.post.req", {15'd0, mem_req}, 16'd0);
    chk("mrst.post.addr", mem_addr, 16'h0000);
    chk("mrst.post.wdata", mem_wdata, 16'h0000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
